// File: rtl/kernel_switch_ctrl.sv
// kernel_switch_ctrl
//   Frame-synchronous owner of the 3x3 kernel ROM address. A host request
//   (valid/ready) or an auto-mode step is applied only on i_frame_start. The
//   coefficient set is flagged valid once the ROM's registered output has
//   settled. The block also supplies the per-kernel normalisation shift and bias.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_frame_start       one-cycle pulse ahead of each frame
//   i_auto_mode         1 = step through kernels every FRAMES_PER_STEP frames
//   i_req_valid/kernel  host request; o_req_ready = no request pending
//   o_req_err           pulse: accepted request was out of range and dropped
//   o_kernel_address    kernel ROM address
//   o_kernel_valid      ROM coefficients stable for o_kernel_address
//   o_norm_shift/o_bias normalisation for the MAC stage
//   o_switch_done       pulse: a host-requested switch has completed
//
// State  | meaning
// LOAD   | address just changed, waiting LOAD_LATENCY cycles for the ROM
// ACTIVE | coefficients stable, frame starts may trigger a switch
module kernel_switch_ctrl #(
  parameter int KERNEL_ADDR_WIDTH = 3,
  parameter int NUM_KERNELS       = 8,
  parameter int LOAD_LATENCY      = 1,
  parameter int FRAMES_PER_STEP   = 60,
  parameter int FRAME_CNT_WIDTH   = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_frame_start,
  input  logic                         i_auto_mode,
  input  logic                         i_req_valid,
  input  logic [KERNEL_ADDR_WIDTH-1:0] i_req_kernel,
  output logic                         o_req_ready,
  output logic                         o_req_err,
  output logic [KERNEL_ADDR_WIDTH-1:0] o_kernel_address,
  output logic                         o_kernel_valid,
  output logic [3:0]                   o_norm_shift,
  output logic [7:0]                   o_bias,
  output logic                         o_switch_done
);

  localparam int KW  = KERNEL_ADDR_WIDTH;
  localparam int LCW = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
  localparam logic [LCW-1:0]             LOAD_LAST   = LCW'(LOAD_LATENCY - 1);
  localparam logic [FRAME_CNT_WIDTH-1:0] FRAME_LAST  = FRAME_CNT_WIDTH'(FRAMES_PER_STEP - 1);
  localparam logic [KW-1:0]              KERNEL_LAST = KW'(NUM_KERNELS - 1);
  localparam logic [KW:0]                KERNEL_LIM  = (KW + 1)'(NUM_KERNELS);

  typedef enum logic {S_LOAD = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t                     state, state_nxt;
  logic [LCW-1:0]             load_cnt, load_cnt_nxt;
  logic                       pending, pending_nxt;
  logic [KW-1:0]              pend_idx, pend_idx_nxt;
  logic                       host_load, host_load_nxt;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt, frame_cnt_nxt;
  logic [KW-1:0]              addr_nxt, cand;
  logic                       valid_nxt, err_nxt, done_nxt, do_load;
  logic [3:0]                 shift_nxt;
  logic [7:0]                 bias_nxt;

  function automatic logic [11:0] norm_entry(input logic [KW-1:0] idx);
    case (int'(idx))
      5:       norm_entry = {4'd4, 8'd0};
      6:       norm_entry = {4'd0, 8'd128};
      default: norm_entry = 12'd0;
    endcase
  endfunction

  assign o_req_ready = ~pending;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= S_LOAD;
      load_cnt         <= '0;
      pending          <= 1'b0;
      pend_idx         <= '0;
      host_load        <= 1'b0;
      frame_cnt        <= '0;
      o_kernel_address <= '0;
      o_kernel_valid   <= 1'b0;
      o_norm_shift     <= '0;
      o_bias           <= '0;
      o_req_err        <= 1'b0;
      o_switch_done    <= 1'b0;
    end else begin
      state            <= state_nxt;
      load_cnt         <= load_cnt_nxt;
      pending          <= pending_nxt;
      pend_idx         <= pend_idx_nxt;
      host_load        <= host_load_nxt;
      frame_cnt        <= frame_cnt_nxt;
      o_kernel_address <= addr_nxt;
      o_kernel_valid   <= valid_nxt;
      o_norm_shift     <= shift_nxt;
      o_bias           <= bias_nxt;
      o_req_err        <= err_nxt;
      o_switch_done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    load_cnt_nxt  = load_cnt;
    pending_nxt   = pending;
    pend_idx_nxt  = pend_idx;
    host_load_nxt = host_load;
    frame_cnt_nxt = frame_cnt;
    addr_nxt      = o_kernel_address;
    valid_nxt     = o_kernel_valid;
    shift_nxt     = o_norm_shift;
    bias_nxt      = o_bias;
    err_nxt       = 1'b0;
    done_nxt      = 1'b0;
    cand          = pend_idx;
    do_load       = 1'b0;

    // Out-of-range requests are consumed (ready stays high) and reported.
    if (i_req_valid && !pending) begin
      if ({1'b0, i_req_kernel} < KERNEL_LIM) begin
        pending_nxt  = 1'b1;
        pend_idx_nxt = i_req_kernel;
      end else begin
        err_nxt = 1'b1;
      end
    end

    if (!i_auto_mode) frame_cnt_nxt = '0;

    case (state)
      S_LOAD: begin
        if (load_cnt == LOAD_LAST) begin
          state_nxt    = S_ACTIVE;
          load_cnt_nxt = '0;
          valid_nxt    = 1'b1;
          // Pending stays set through a host load so no new request slips in.
          if (host_load) begin
            host_load_nxt = 1'b0;
            pending_nxt   = 1'b0;
            done_nxt      = 1'b1;
          end
        end else begin
          load_cnt_nxt = load_cnt + 1'b1;
        end
      end
      S_ACTIVE: begin
        if (i_frame_start) begin
          if (pending) begin
            frame_cnt_nxt = '0;
            cand          = pend_idx;
            if (pend_idx != o_kernel_address) begin
              do_load       = 1'b1;
              host_load_nxt = 1'b1;
            end else begin
              pending_nxt = 1'b0;
              done_nxt    = 1'b1;
            end
          end else if (i_auto_mode) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt_nxt = '0;
              cand    = (o_kernel_address == KERNEL_LAST) ? '0 : o_kernel_address + 1'b1;
              do_load = (cand != o_kernel_address);
            end else begin
              frame_cnt_nxt = frame_cnt + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase

    if (do_load) begin
      addr_nxt               = cand;
      {shift_nxt, bias_nxt}  = norm_entry(cand);
      valid_nxt              = 1'b0;
      state_nxt              = S_LOAD;
      load_cnt_nxt           = '0;
    end
  end

endmodule

// File: doc/kernel_switch_ctrl.md
Name: kernel_switch_ctrl

Overview:
- Frame-synchronous controller for the 3x3 convolution kernel ROM; sole driver of its kernel address input.
- Accepts kernel-change requests from a host (switches or UART) through a valid/ready handshake, or steps through kernels automatically in demo mode.
- Applies every change only on a frame boundary. Flags the coefficient set valid once the ROM's registered output has settled.
- Supplies per-kernel normalisation shift and output bias to the convolution/MAC stage.

Parameters:
- KERNEL_ADDR_WIDTH, 3, width of the kernel ROM address.
- NUM_KERNELS, 8, number of populated kernels; valid indices are 0..NUM_KERNELS-1.
- LOAD_LATENCY, 1, cycles from an address change to stable ROM coefficients.
- FRAMES_PER_STEP, 60, frames per kernel in auto mode (>=1).
- FRAME_CNT_WIDTH, 8, auto-mode frame counter width; must hold FRAMES_PER_STEP-1.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_frame_start  in  1  one-cycle pulse before the first pixel of each frame.
- i_auto_mode  in  1  1 = cycle kernels automatically.
- i_req_valid  in  1  host request valid.
- i_req_kernel  in  KERNEL_ADDR_WIDTH  requested kernel index.
- o_req_ready  out  1  controller can accept a request.
- o_req_err  out  1  one-cycle pulse: accepted request was out of range and dropped.
- o_kernel_address  out  KERNEL_ADDR_WIDTH  to kernel ROM address.
- o_kernel_valid  out  1  ROM coefficients are stable for the current address.
- o_norm_shift  out  4  right shift applied to the MAC sum.
- o_bias  out  8  unsigned offset added after the shift.
- o_switch_done  out  1  one-cycle pulse when a requested switch completes.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Outputs: o_kernel_address=0, o_kernel_valid=0, o_norm_shift=0, o_bias=0, o_req_ready=1, o_req_err=0, o_switch_done=0.
  - Internal state: pending flag=0, frame counter=0, state=LOAD, load counter=0.
  - Reset asserted mid-operation aborts everything, drops any pending request and restarts from this state.
- States:
  - LOAD: o_kernel_valid=0; load counter counts up each cycle. When it reaches LOAD_LATENCY-1, go to ACTIVE next edge.
  - ACTIVE: o_kernel_valid=1.
  - Boot: first ACTIVE cycle is cycle 1+LOAD_LATENCY after reset release, with kernel 0.
- Host handshake:
  - Transfer occurs when i_req_valid & o_req_ready at a rising edge.
  - If index < NUM_KERNELS: store it in the pending register, set pending=1, o_req_ready=0 next cycle.
  - If index >= NUM_KERNELS: pulse o_req_err next cycle; pending unchanged; ready stays 1.
  - o_req_ready = ~pending, in any state.
- Switch trigger: i_frame_start sampled in ACTIVE with a candidate available.
  - Candidate priority: host pending > auto step.
  - Different index: next cycle o_kernel_address=candidate, o_kernel_valid=0, o_norm_shift/o_bias updated, state=LOAD. After LOAD_LATENCY cycles, o_kernel_valid=1, o_switch_done pulses once, pending clears (o_req_ready=1 the same cycle).
  - Same index as current: no reload; o_kernel_valid stays 1; pending clears and o_switch_done pulses next cycle.
  - Auto-step switches do not pulse o_switch_done.
- Frame-start edge cases:
  - i_frame_start during LOAD is ignored; the pending request waits for the next frame.
  - Request accepted in the same cycle as i_frame_start is not applied on that frame.
- Auto mode:
  - Frame counter increments on each i_frame_start in ACTIVE while i_auto_mode=1.
  - When counter==FRAMES_PER_STEP-1 on i_frame_start: candidate=(current+1) wrapping NUM_KERNELS-1 to 0; counter returns to 0.
  - Host-applied switch also resets counter to 0.
  - i_auto_mode=0 holds counter at 0.
- Normalisation table (index: shift, bias): 0:0,0; 1:0,0; 2:0,0; 3:0,0; 4:0,0; 5:4,0; 6:0,128; 7:0,0. Indices >=8 (wider builds): 0,0.
- All outputs are registered; no combinational path from inputs to outputs except o_req_ready from internal pending.

Test Plan:
- Reset release, LOAD_LATENCY=1 -> o_kernel_valid rises on cycle 2 after release; address 0, shift 0, bias 0, ready 1.
- Host request 5 in mid-frame, i_frame_start 10 cycles later -> ready low from next cycle; after frame_start: address 5, valid 0 one cycle, then valid 1, shift 4, switch_done pulse, ready 1.
- Request 6 accepted in the same cycle as i_frame_start -> no change that frame; applied on the following i_frame_start; bias 128.
- NUM_KERNELS=6, request 7 -> o_req_err one pulse, ready stays 1, address unchanged.
- Auto mode, FRAMES_PER_STEP=3, starting at kernel 7 -> wraps to 0 on 3rd frame_start; host request 2 pending at next step -> 2 wins, counter resets to 0.
- Assert i_rst_n low mid-LOAD with request pending -> outputs at reset values immediately; pending dropped; kernel 0 reloads after release.
